// File: rtl/instr_cycle_sequencer_if.sv
// Handshake/strobe bundle between the instruction-cycle sequencer and the core (step/halted with SEQ_SINGLE_STEP_EN).
// Purely structural: no latency, no flow control of its own.
interface instr_cycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             branch_taken;
  logic             inst_fetch;
  logic             data_fetch;
  logic             alu_results;
  logic             save_files;
  logic             pc_inc;
  logic             write_en;
  logic             flush;
  logic [CNT_W-1:0] retired;
`ifdef SEQ_SINGLE_STEP_EN
  logic             step;
  logic             halted;

  modport master (
    output stall, branch_taken, step,
    input  inst_fetch, data_fetch, alu_results, save_files,
    input  pc_inc, write_en, flush, retired, halted
  );

  modport slave (
    input  stall, branch_taken, step,
    output inst_fetch, data_fetch, alu_results, save_files,
    output pc_inc, write_en, flush, retired, halted
  );
`else
  modport master (
    output stall, branch_taken,
    input  inst_fetch, data_fetch, alu_results, save_files,
    input  pc_inc, write_en, flush, retired
  );

  modport slave (
    input  stall, branch_taken,
    output inst_fetch, data_fetch, alu_results, save_files,
    output pc_inc, write_en, flush, retired
  );
`endif
endinterface

// File: rtl/instr_cycle_sequencer.sv
// Four-phase Q1..Q4 instruction-cycle sequencer with post-branch flush cycle; SEQ_SINGLE_STEP_EN adds a HALT/step mode.
// Strobes decode registered state (same-cycle stall mask); stall holds the current phase, no other backpressure.
module instr_cycle_sequencer #(
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    reset,
  instr_cycle_sequencer_if.slave bus
);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, Q1 = 3'd1, Q2 = 3'd2, Q3 = 3'd3, Q4 = 3'd4, HALT = 3'd5
  } state_t;
  localparam state_t CYCLE_END = HALT;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, Q1 = 3'd1, Q2 = 3'd2, Q3 = 3'd3, Q4 = 3'd4
  } state_t;
  localparam state_t CYCLE_END = Q1;
`endif

  state_t           state_q;
  state_t           state_d;
  logic             flush_q;
  logic             flush_pending_q;
  logic [CNT_W-1:0] retired_q;
  logic             leave_q3;
  logic             leave_q4;

  assign leave_q3 = (state_q == Q3) && !bus.stall;
  assign leave_q4 = (state_q == Q4) && !bus.stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      flush_q         <= 1'b0;
      flush_pending_q <= 1'b0;
      retired_q       <= '0;
    end else begin
      state_q <= state_d;
      // A branch resolved inside a flush cycle belongs to the squashed instruction.
      if (leave_q3 && bus.branch_taken && !flush_q)
        flush_pending_q <= 1'b1;
      if (leave_q4) begin
        flush_q         <= flush_pending_q;
        flush_pending_q <= 1'b0;
        if (!flush_q)
          retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = CYCLE_END;
      Q1:   if (!bus.stall) state_d = Q2;
      Q2:   if (!bus.stall) state_d = Q3;
      Q3:   if (!bus.stall) state_d = Q4;
      Q4:   if (!bus.stall) state_d = CYCLE_END;
`ifdef SEQ_SINGLE_STEP_EN
      HALT: if (bus.step) state_d = Q1;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.inst_fetch  = (state_q == Q1) && !bus.stall;
    bus.data_fetch  = (state_q == Q2) && !bus.stall;
    bus.alu_results = (state_q == Q3) && !bus.stall;
    bus.save_files  = (state_q == Q4) && !bus.stall;
    bus.pc_inc      = bus.save_files;
    bus.write_en    = bus.save_files && !flush_q;
    bus.flush       = flush_q;
    bus.retired     = retired_q;
`ifdef SEQ_SINGLE_STEP_EN
    bus.halted      = (state_q == HALT);
`endif
  end

endmodule
